// File: rtl/gsim_job_arbiter.sv
// Round-robin job arbiter in front of a shared GSIM solver: grants one 16-word b-vector load,
// captures the solver's unthrottled 16-word result burst, then drains it over a valid/ready port.
module gsim_job_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 2047,
  parameter int TW      = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 res_valid,
  output logic [31:0]          res_data,
  output logic [1:0]           res_id,
  output logic                 res_last,
  input  logic                 res_ready,
  output logic                 sol_in_en,
  output logic [15:0]          sol_b_in,
  input  logic                 sol_out_valid,
  input  logic [31:0]          sol_x_out,
  output logic                 sol_rst,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t          state_q;
  logic [1:0]      g_q;
  logic [1:0]      last_q;
  logic [3:0]      wcnt_q;
  logic [3:0]      ccnt_q;
  logic [3:0]      rd_q;
  logic [TW-1:0]   wdog_q;
  logic            res_valid_q;
  logic            res_last_q;
  logic [1:0]      res_id_q;
  logic [31:0]     res_data_q;
  logic            timeout_err_q;
  logic            sol_rst_q;

  logic [31:0]     res_buf [16];

  logic            grant_found;
  logic [1:0]      grant_idx;
  logic            sel_valid;
  logic [15:0]     sel_data;
  logic            load_hs;
  logic            drain_hs;
  logic            buf_we;
  logic [3:0]      buf_waddr;
  logic [3:0]      rd_addr;

  // Search upward from last_q+1 so the previous winner is considered last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_q;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!grant_found && req_valid[i] && (((int'(last_q) + k) % N_REQ) == i)) begin
          grant_found = 1'b1;
          grant_idx   = 2'(i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (g_q == 2'(i)) begin
        sel_valid    = req_valid[i];
        sel_data     = req_data[16*i +: 16];
        req_ready[i] = (state_q == S_LOAD);
      end
    end
  end

  assign load_hs   = (state_q == S_LOAD) && sel_valid;
  assign sol_in_en = load_hs;
  assign sol_b_in  = load_hs ? sel_data : 16'd0;

  assign drain_hs  = (state_q == S_DRAIN) && res_valid_q && res_ready;
  assign rd_addr   = drain_hs ? (rd_q + 4'd1) : rd_q;

  assign buf_we    = sol_out_valid && ((state_q == S_WAIT) || (state_q == S_CAPTURE));
  assign buf_waddr = (state_q == S_WAIT) ? 4'd0 : ccnt_q;

  always_ff @(posedge clk) begin
    if (buf_we) begin
      res_buf[buf_waddr] <= sol_x_out;
    end
  end

  // Read address runs one word ahead on a handshake so res_data is registered yet never bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_data_q <= '0;
    end else if ((state_q == S_CAPTURE) || (state_q == S_DRAIN)) begin
      res_data_q <= res_buf[rd_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      g_q           <= '0;
      last_q        <= 2'(N_REQ - 1);
      wcnt_q        <= '0;
      ccnt_q        <= '0;
      rd_q          <= '0;
      wdog_q        <= '0;
      res_valid_q   <= 1'b0;
      res_last_q    <= 1'b0;
      res_id_q      <= '0;
      timeout_err_q <= 1'b0;
      sol_rst_q     <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      sol_rst_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            g_q     <= grant_idx;
            last_q  <= grant_idx;
            wcnt_q  <= '0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (load_hs) begin
            if (wcnt_q == 4'd15) begin
              wcnt_q  <= '0;
              wdog_q  <= '0;
              state_q <= S_WAIT;
            end else begin
              wcnt_q <= wcnt_q + 4'd1;
            end
          end
        end
        S_WAIT: begin
          if (sol_out_valid) begin
            ccnt_q  <= 4'd1;
            state_q <= S_CAPTURE;
          end else if (wdog_q == TW'(TIMEOUT - 1)) begin
            // Burst never came: kick the solver and drop the job without results.
            timeout_err_q <= 1'b1;
            sol_rst_q     <= 1'b1;
            wdog_q        <= '0;
            state_q       <= S_IDLE;
          end else begin
            wdog_q <= wdog_q + TW'(1);
          end
        end
        S_CAPTURE: begin
          if (sol_out_valid) begin
            if (ccnt_q == 4'd15) begin
              ccnt_q      <= '0;
              rd_q        <= '0;
              res_valid_q <= 1'b1;
              res_last_q  <= 1'b0;
              res_id_q    <= g_q;
              state_q     <= S_DRAIN;
            end else begin
              ccnt_q <= ccnt_q + 4'd1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_hs) begin
            if (rd_q == 4'd15) begin
              rd_q        <= '0;
              res_valid_q <= 1'b0;
              res_last_q  <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              rd_q       <= rd_q + 4'd1;
              res_last_q <= (rd_q == 4'd14);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_id      = res_id_q;
  assign res_last    = res_last_q;
  assign sol_rst     = sol_rst_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_gsim_job_arbiter.sv
// Directed bench for gsim_job_arbiter with a behavioural solver model and a result collector.
module tb_gsim_job_arbiter;
  localparam int N_REQ   = 2;
  localparam int TIMEOUT = 2047;
  localparam int TW      = 11;
  localparam int LAT     = 1120;

  logic                clk = 1'b0;
  logic                reset;
  logic [N_REQ-1:0]    req_valid;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                res_valid;
  logic [31:0]         res_data;
  logic [1:0]          res_id;
  logic                res_last;
  logic                res_ready;
  logic                sol_in_en;
  logic [15:0]         sol_b_in;
  logic                sol_out_valid;
  logic [31:0]         sol_x_out;
  logic                sol_rst;
  logic                busy;
  logic                timeout_err;

  always #5 clk = ~clk;

  gsim_job_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_last(res_last),
    .res_ready(res_ready),
    .sol_in_en(sol_in_en), .sol_b_in(sol_b_in),
    .sol_out_valid(sol_out_valid), .sol_x_out(sol_x_out),
    .sol_rst(sol_rst), .busy(busy), .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // requester driver state
  int jobs_left[N_REQ];
  int idx[N_REQ];
  int lc[N_REQ];
  int jobcnt[N_REQ];
  bit bubble_en[N_REQ];
  bit hs_pend[N_REQ];
  bit bub;

  // solver model / collector state
  logic [31:0] r_data[128];
  logic [1:0]  r_id[128];
  logic        r_last[128];
  logic [15:0] b_rec[128];
  int nres, nb, strobes, lat_cnt, emit_k, noresp_cnt;
  bit emitting, bp_en, prev_stall;
  int bp_ph, resv_cnt, rr0_cnt, rr1_early, stall_cnt;
  int t_wait, to_cnt, rst_cnt, to_delay, resv_at_to;
  logic busy_at_to;
  logic [31:0] sol_base;
  logic [33:0] prev_word;

  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (hs_pend[i]) begin
          hs_pend[i] = 1'b0;
          idx[i]++;
          if (idx[i] == 16) begin
            idx[i] = 0;
            lc[i]  = 0;
            jobcnt[i]++;
            jobs_left[i]--;
          end
        end
        if (jobs_left[i] > 0) begin
          bub = 1'b0;
          if (req_ready[i]) begin
            bub = bubble_en[i] && (lc[i] == 3 || lc[i] == 9);
            lc[i]++;
          end
          req_valid[i] = !bub;
          req_data[16*i +: 16] = 16'((i << 12) + (jobcnt[i] << 8) + idx[i] + 1);
          hs_pend[i] = req_ready[i] && !bub;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    sol_out_valid = 1'b0;
    sol_x_out     = '0;
    res_ready     = 1'b0;
    forever begin
      @(negedge clk);
      res_ready = bp_en ? (bp_ph == 0) : 1'b1;
      bp_ph = (bp_ph + 1) % 3;
      if (prev_stall) check_val("stall_hold", {res_id, res_data}, prev_word);
      if (res_valid && res_ready && nres < 128) begin
        r_data[nres] = res_data;
        r_id[nres]   = res_id;
        r_last[nres] = res_last;
        nres++;
      end
      prev_stall = res_valid && !res_ready;
      if (prev_stall) stall_cnt++;
      prev_word = {res_id, res_data};
      if (res_valid) resv_cnt++;
      if (req_ready[0]) rr0_cnt++;
      if (req_ready[1] && nres == 0) rr1_early++;
      if (sol_in_en && nb < 128) begin
        b_rec[nb] = sol_b_in;
        nb++;
        strobes++;
        if (strobes == 16) begin
          strobes = 0;
          t_wait  = cyc + 1;
          if (noresp_cnt > 0) noresp_cnt--;
          else lat_cnt = LAT;
        end
      end
      if (emitting) begin
        sol_out_valid = 1'b1;
        sol_x_out     = sol_base + 32'(emit_k);
        emit_k++;
        if (emit_k == 16) begin
          emitting = 1'b0;
          sol_base = sol_base + 32'h100;
        end
      end else begin
        sol_out_valid = 1'b0;
        if (lat_cnt > 0) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            emitting = 1'b1;
            emit_k   = 0;
          end
        end
      end
      if (timeout_err) begin
        if (to_cnt == 0) begin
          to_delay   = cyc - t_wait;
          busy_at_to = busy;
          resv_at_to = resv_cnt;
        end
        to_cnt++;
      end
      if (sol_rst) begin
        rst_cnt++;
        strobes  = 0;
        emitting = 1'b0;
        lat_cnt  = 0;
      end
    end
  end

  task automatic clear_test();
    nres = 0; nb = 0; resv_cnt = 0; rr0_cnt = 0; rr1_early = 0; stall_cnt = 0;
    to_cnt = 0; rst_cnt = 0; to_delay = -1; resv_at_to = -1; busy_at_to = 1'b1;
    sol_base = 32'h100; prev_stall = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      jobcnt[i] = 0; bubble_en[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      jobs_left[i] = 0; idx[i] = 0; lc[i] = 0; hs_pend[i] = 1'b0;
    end
    strobes = 0; lat_cnt = 0; emitting = 1'b0; emit_k = 0; noresp_cnt = 0;
    bp_en = 1'b0; bp_ph = 0;
    clear_test();
    @(posedge clk); @(posedge clk); #3;
    check_val("rst_busy", busy, 0);
    check_val("rst_res", {res_valid, res_last, res_id, res_data}, 0);
    check_val("rst_ready", req_ready, 0);
    check_val("rst_sol", {sol_in_en, sol_b_in, sol_rst, timeout_err}, 0);
    reset = 1'b0;
    @(posedge clk); #3;
  endtask

  task automatic run_wait(input int nexp, input int maxc, input string nm);
    int c;
    c = 0;
    while (c < maxc && !(nres >= nexp && !busy)) begin
      @(posedge clk); #3;
      c++;
    end
    check_val({nm, "_nres"}, nres, nexp);
    check_val({nm, "_idle"}, busy, 0);
  endtask

  task automatic check_jobs(input int nj, input logic [7:0] idv, input int boff, input string nm);
    int rj[4];
    logic [1:0] id;
    int p;
    rj = '{default: 0};
    for (int j = 0; j < nj; j++) begin
      id = idv[2*j +: 2];
      for (int k = 0; k < 16; k++) begin
        p = 16*j + k;
        check_val($sformatf("%s_res%0d_%0d", nm, j, k), {r_id[p], r_last[p], r_data[p]},
                  {id, (k == 15), 32'(32'h100*(j+1) + k)});
        check_val($sformatf("%s_b%0d_%0d", nm, j, k), b_rec[boff + p],
                  16'((int'(id) << 12) + (rj[id] << 8) + k + 1));
      end
      rj[id]++;
      $display("%s job %0d: requester %0d, 16 results at %0d", nm, j, id, cyc);
    end
  endtask

  initial begin
    reset = 1'b1;
    do_reset();

    // single job from requester 0
    jobs_left[0] = 1;
    run_wait(16, 1500, "single");
    check_val("single_strobes", nb, 16);
    check_jobs(1, 8'b00, 0, "single");

    // simultaneous requests straight after reset
    do_reset();
    jobs_left[0] = 1; jobs_left[1] = 1;
    run_wait(32, 3000, "contend");
    check_val("contend_rr1_during_job0", rr1_early, 0);
    check_jobs(2, 8'b0100, 0, "contend");

    // both requesters stay pending: grants must alternate
    clear_test();
    jobs_left[0] = 2; jobs_left[1] = 2;
    run_wait(64, 6000, "fair");
    check_jobs(4, 8'b01000100, 0, "fair");

    // load bubbles on LOAD cycles 3 and 9
    clear_test();
    bubble_en[0] = 1'b1;
    jobs_left[0] = 1;
    run_wait(16, 1500, "bubble");
    check_val("bubble_strobes", nb, 16);
    check_val("bubble_load_cycles", rr0_cnt, 18);
    check_jobs(1, 8'b00, 0, "bubble");

    // result backpressure 1,0,0 pattern
    clear_test();
    bp_en = 1'b1; bp_ph = 0;
    jobs_left[1] = 1;
    run_wait(16, 1500, "bp");
    bp_en = 1'b0;
    check_val("bp_stalls_seen", (stall_cnt > 0), 1);
    check_jobs(1, 8'b01, 0, "bp");

    // watchdog: first burst never arrives, pending requester 1 served afterwards
    clear_test();
    noresp_cnt = 1;
    jobs_left[0] = 1; jobs_left[1] = 1;
    run_wait(16, 4500, "wdog");
    check_val("wdog_delay", to_delay, TIMEOUT);
    check_val("wdog_to_pulses", to_cnt, 1);
    check_val("wdog_rst_pulses", rst_cnt, 1);
    check_val("wdog_busy_at_to", busy_at_to, 0);
    check_val("wdog_resvalid_before_to", resv_at_to, 0);
    check_val("wdog_strobes", nb, 32);
    check_jobs(1, 8'b01, 16, "wdog");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
